// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard unit: register index, forwarding select constant,
// and the load-shadow entry layout.
package hazard_scoreboard_pkg;

    typedef logic [4:0] regbits_t;

    // Select value meaning "take the operand from the register file"
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic     valid;
        regbits_t dst;
    } ldshadow_t;

endpackage

// File: rtl/hazard_scoreboard_load_shadow.sv
// Load shadow: remembers loads for LOAD_LAT cycles after they enter EX and
// flags any decode source register that would read a not-yet-forwardable result.
module hazard_scoreboard_load_shadow
    import hazard_scoreboard_pkg::*;
#(
    parameter int LOAD_LAT = 1
) (
    input  logic     CLK,
    input  logic     nRST,
    input  logic     i_ld_issue,
    input  regbits_t i_ld_dst,
    input  regbits_t i_src_a,
    input  regbits_t i_src_b,
    output logic     o_match
);

    ldshadow_t r_shadow [LOAD_LAT];

    // Shift loads through the shadow every edge; stalls never hold it because
    // the loads are already past decode.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < LOAD_LAT; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_shadow[0].valid <= i_ld_issue && (i_ld_dst != '0);
            r_shadow[0].dst   <= i_ld_dst;
            for (int i = 1; i < LOAD_LAT; i++) begin
                r_shadow[i] <= r_shadow[i-1];
            end
        end
    end

    // Any valid entry whose destination equals a nonzero source is a hit
    always_comb begin
        o_match = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (r_shadow[i].valid &&
                (((i_src_a != '0) && (r_shadow[i].dst == i_src_a)) ||
                 ((i_src_b != '0) && (r_shadow[i].dst == i_src_b)))) begin
                o_match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit beside the decode/execute boundary: multi-stage forwarding,
// load-use shadow, long-latency register scoreboard and a saturating stall counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter  int NSTAGE   = 2,
    parameter  int LOAD_LAT = 1,
    parameter  int CNTW     = 16,
    localparam int SELW     = $clog2(NSTAGE + 1)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    id_valid,
    input  regbits_t                id_rs,
    input  regbits_t                id_rt,
    input  regbits_t                ex_rs,
    input  regbits_t                ex_rt,
    input  logic                    ex_memwrite,
    input  logic     [NSTAGE-1:0]   fwd_wen,
    input  regbits_t [NSTAGE-1:0]   fwd_dst,
    input  logic                    ld_issue,
    input  regbits_t                ld_dst,
    input  logic                    issue_long,
    input  regbits_t                issue_dst,
    input  logic                    long_done,
    input  regbits_t                long_dst,
    input  logic                    flush,
    output logic                    stall,
    output logic     [SELW-1:0]     forwarda_sel,
    output logic     [SELW-1:0]     forwardb_sel,
    output logic     [SELW-1:0]     memdata_sel,
    output logic     [CNTW-1:0]     stall_cycles
);

    logic [31:0]     r_pending;
    logic [31:0]     w_pending_nxt;
    logic [CNTW-1:0] r_stall_cnt;
    logic [SELW-1:0] w_sel_a;
    logic [SELW-1:0] w_sel_b;
    logic            w_shadow_hit;
    logic            w_sb_set;

    hazard_scoreboard_load_shadow #(
        .LOAD_LAT (LOAD_LAT)
    ) u_load_shadow (
        .CLK        (CLK),
        .nRST       (nRST),
        .i_ld_issue (ld_issue),
        .i_ld_dst   (ld_dst),
        .i_src_a    (id_rs),
        .i_src_b    (id_rt),
        .o_match    (w_shadow_hit)
    );

    // Forwarding priority: scan far-to-near so the nearest producer overwrites
    always_comb begin
        w_sel_a = SELW'(FWD_RF);
        w_sel_b = SELW'(FWD_RF);
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (fwd_wen[k] && (fwd_dst[k] != '0) && (fwd_dst[k] == ex_rs)) begin
                w_sel_a = SELW'(k + 1);
            end
            if (fwd_wen[k] && (fwd_dst[k] != '0) && (fwd_dst[k] == ex_rt)) begin
                w_sel_b = SELW'(k + 1);
            end
        end
    end

    // Stores route the rt result to the store-data mux instead of the ALU B input
    always_comb begin
        forwarda_sel = w_sel_a;
        forwardb_sel = ex_memwrite ? SELW'(FWD_RF) : w_sel_b;
        memdata_sel  = ex_memwrite ? w_sel_b : SELW'(FWD_RF);
    end

    // Stall on load shadow, pending source (RAW) or pending destination (WAW)
    always_comb begin
        stall = id_valid && !flush &&
                (w_shadow_hit ||
                 r_pending[id_rs] || r_pending[id_rt] ||
                 (issue_long && r_pending[issue_dst]));
    end

    // Scoreboard next state: clear first so a same-register set wins
    always_comb begin
        w_sb_set      = issue_long && id_valid && !stall && !flush && (issue_dst != '0);
        w_pending_nxt = r_pending;
        if (long_done) begin
            w_pending_nxt[long_dst] = 1'b0;
        end
        if (w_sb_set) begin
            w_pending_nxt[issue_dst] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two configurations driven by the same stimulus,
// each compared every cycle against a behavioural model (load history by issue
// cycle, per-register pending flags, integer stall counter).
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic            CLK = 1'b0;
    logic            nRST;
    logic            id_valid, ex_memwrite, ld_issue, issue_long, long_done, flush;
    regbits_t        id_rs, id_rt, ex_rs, ex_rt, ld_dst, issue_dst, long_dst;
    logic     [2:0]  fwd_wen;
    regbits_t [2:0]  fwd_dst;

    logic            stall_a, stall_b;
    logic     [1:0]  fa_a, fb_a, md_a, fa_b, fb_b, md_b;
    logic     [3:0]  sc_a;
    logic     [15:0] sc_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    hazard_scoreboard #(.NSTAGE(3), .LOAD_LAT(1), .CNTW(4)) u_dut_a (
        .CLK(CLK), .nRST(nRST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memwrite(ex_memwrite),
        .fwd_wen(fwd_wen), .fwd_dst(fwd_dst), .ld_issue(ld_issue), .ld_dst(ld_dst),
        .issue_long(issue_long), .issue_dst(issue_dst), .long_done(long_done),
        .long_dst(long_dst), .flush(flush), .stall(stall_a), .forwarda_sel(fa_a),
        .forwardb_sel(fb_a), .memdata_sel(md_a), .stall_cycles(sc_a)
    );

    hazard_scoreboard #(.NSTAGE(2), .LOAD_LAT(3), .CNTW(16)) u_dut_b (
        .CLK(CLK), .nRST(nRST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memwrite(ex_memwrite),
        .fwd_wen(fwd_wen[1:0]), .fwd_dst(fwd_dst[1:0]), .ld_issue(ld_issue), .ld_dst(ld_dst),
        .issue_long(issue_long), .issue_dst(issue_dst), .long_done(long_done),
        .long_dst(long_dst), .flush(flush), .stall(stall_b), .forwarda_sel(fa_b),
        .forwardb_sel(fb_b), .memdata_sel(md_b), .stall_cycles(sc_b)
    );

    // ---------------- reference model ----------------
    typedef struct { int c; int d; } ld_t;
    ld_t lq[$];
    int  cyc = 0;
    bit  pend [2][32];
    int  cnt  [2];
    bit  es   [2];
    int  lat  [2] = '{1, 3};
    int  nst  [2] = '{3, 2};
    int  cmax [2] = '{15, 65535};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int exp_fwd(int i, int src);
        for (int k = 0; k < nst[i]; k++)
            if (fwd_wen[k] && fwd_dst[k] != 0 && int'(fwd_dst[k]) == src) return k + 1;
        return 0;
    endfunction

    function automatic bit exp_shadow(int i);
        foreach (lq[j]) begin
            int age = cyc - lq[j].c;
            if (age >= 1 && age <= lat[i] &&
                ((id_rs != 0 && lq[j].d == int'(id_rs)) || (id_rt != 0 && lq[j].d == int'(id_rt))))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit exp_stall(int i);
        return id_valid && !flush &&
               (exp_shadow(i) || pend[i][id_rs] || pend[i][id_rt] ||
                (issue_long && pend[i][issue_dst]));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0;
            for (int r = 0; r < 32; r++) pend[i][r] = 1'b0;
        end
        lq.delete();
    endtask

    task automatic idle();
        id_valid = 0; ex_memwrite = 0; ld_issue = 0; issue_long = 0; long_done = 0; flush = 0;
        id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ld_dst = 0; issue_dst = 0; long_dst = 0;
        fwd_wen = 0; fwd_dst = '0;
    endtask

    // Compare every output of both instances mid-cycle
    task automatic sample();
        @(negedge CLK);
        for (int i = 0; i < 2; i++) es[i] = exp_stall(i);
        chk("stall_a", stall_a, es[0]);
        chk("fwda_a", fa_a, exp_fwd(0, ex_rs));
        chk("fwdb_a", fb_a, ex_memwrite ? 0 : exp_fwd(0, ex_rt));
        chk("mdat_a", md_a, ex_memwrite ? exp_fwd(0, ex_rt) : 0);
        chk("cnt_a", sc_a, cnt[0]);
        chk("stall_b", stall_b, es[1]);
        chk("fwda_b", fa_b, exp_fwd(1, ex_rs));
        chk("fwdb_b", fb_b, ex_memwrite ? 0 : exp_fwd(1, ex_rt));
        chk("mdat_b", md_b, ex_memwrite ? exp_fwd(1, ex_rt) : 0);
        chk("cnt_b", sc_b, cnt[1]);
    endtask

    // Clock edge: update model with the inputs held this cycle
    task automatic advance();
        @(posedge CLK);
        for (int i = 0; i < 2; i++) begin
            if (long_done) pend[i][long_dst] = 1'b0;
            if (issue_long && id_valid && !es[i] && !flush && issue_dst != 0) pend[i][issue_dst] = 1'b1;
            if (es[i] && cnt[i] < cmax[i]) cnt[i]++;
        end
        if (ld_issue && ld_dst != 0) lq.push_back('{c: cyc, d: int'(ld_dst)});
        cyc++;
        while (lq.size() > 0 && cyc - lq[0].c > 4) void'(lq.pop_front());
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        nRST = 1'b0;
        idle();
        model_reset();
        #12 nRST = 1'b1;

        // reset state
        sample();
        chk("rst_stall", stall_a, 0);
        chk("rst_cnt", sc_a, 0);
        advance();

        // forwarding priority
        fwd_wen = 3'b111; fwd_dst = {5'd5, 5'd5, 5'd5}; ex_rs = 5;
        sample(); chk("prio_near", fa_a, 1); advance();
        fwd_wen = 3'b100;
        sample(); chk("prio_far", fa_a, 3); advance();
        fwd_dst = '0;
        sample(); chk("prio_r0", fa_a, 0); advance();

        // store data
        idle(); ex_memwrite = 1; ex_rt = 7; fwd_wen = 3'b010; fwd_dst[1] = 7;
        sample(); chk("st_mdat", md_a, 2); chk("st_fwdb", fb_a, 0); advance();

        // load-use, then forward from MEM/WB
        idle(); ld_issue = 1; ld_dst = 8;
        step();
        idle(); id_valid = 1; id_rs = 8;
        sample(); chk("lu_stall", stall_a, 1); advance();
        ex_rs = 8; fwd_wen = 3'b010; fwd_dst[1] = 8;
        sample(); chk("lu_release", stall_a, 0); chk("lu_fwd", fa_a, 2); chk("lu_cnt", sc_a, 1); advance();
        idle();
        repeat (4) step();
        ld_issue = 1; ld_dst = 0;
        step();
        idle(); id_valid = 1; id_rs = 0;
        sample(); chk("lu_r0_a", stall_a, 0); chk("lu_r0_b", stall_b, 0); advance();

        // back-to-back loads, deep shadow on instance b
        idle(); ld_issue = 1; ld_dst = 4; step();
        ld_dst = 9; step();
        idle(); step();
        id_valid = 1; id_rt = 9;
        sample(); chk("ll3_s1", stall_b, 1); advance();
        sample(); chk("ll3_s2", stall_b, 1); advance();
        sample(); chk("ll3_rel", stall_b, 0); advance();

        // scoreboard RAW, WAW, release timing, set-wins
        idle(); id_valid = 1; issue_long = 1; issue_dst = 12; step();
        issue_long = 0; id_rs = 12;
        repeat (3) begin sample(); chk("sb_raw", stall_a, 1); advance(); end
        id_rs = 0; issue_long = 1; issue_dst = 12;
        sample(); chk("sb_waw", stall_a, 1); advance();
        issue_long = 0; id_rs = 12; long_done = 1; long_dst = 12;
        sample(); chk("sb_done_t", stall_a, 1); advance();
        issue_long = 1; issue_dst = 12;
        sample(); chk("sb_done_t1", stall_a, 0); advance();
        issue_long = 0; long_done = 0;
        sample(); chk("sb_setwins", stall_a, 1); advance();

        // flush suppresses stall and the scoreboard set
        flush = 1; issue_long = 1; issue_dst = 13;
        sample(); chk("fl_stall", stall_a, 0); advance();
        flush = 0; issue_long = 0; id_rs = 13;
        sample(); chk("fl_noset", stall_a, 0); advance();

        // async reset mid-stall
        id_rs = 12;
        sample(); chk("pre_rst", stall_a, 1);
        #2 nRST = 1'b0;
        #1;
        chk("arst_stall", stall_a, 0);
        chk("arst_cnt_a", sc_a, 0);
        chk("arst_cnt_b", sc_b, 0);
        model_reset();
        @(posedge CLK);
        #1 nRST = 1'b1;
        cyc++;

        // counter saturation
        idle(); id_valid = 1; issue_long = 1; issue_dst = 20; step();
        issue_long = 0; id_rs = 20;
        repeat (20) step();
        idle();
        sample(); chk("sat_a", sc_a, 15); chk("sat_b", sc_b, 20); advance();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            id_valid    = ($urandom_range(0, 9) < 8);
            flush       = ($urandom_range(0, 9) == 0);
            id_rs       = regbits_t'($urandom_range(0, 7));
            id_rt       = regbits_t'($urandom_range(0, 7));
            ex_rs       = regbits_t'($urandom_range(0, 7));
            ex_rt       = regbits_t'($urandom_range(0, 7));
            ex_memwrite = $urandom_range(0, 1);
            fwd_wen     = 3'($urandom_range(0, 7));
            for (int k = 0; k < 3; k++) fwd_dst[k] = regbits_t'($urandom_range(0, 7));
            ld_issue    = ($urandom_range(0, 3) == 0);
            ld_dst      = regbits_t'($urandom_range(0, 7));
            issue_long  = ($urandom_range(0, 4) == 0);
            issue_dst   = regbits_t'($urandom_range(0, 7));
            long_done   = ($urandom_range(0, 2) == 0);
            long_dst    = regbits_t'($urandom_range(0, 7));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
